// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: slot-table TDM arbiter for one shared output register.
// Unused slots idle, or in work-conserving mode go round-robin to another valid lane.
module tdm_slot_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 1,
  parameter int SLOTS  = 8,
  localparam int CW = $clog2(NUM_CH),
  localparam int SW = $clog2(SLOTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_en,
  input  logic                     work_conserve,
  input  logic                     cfg_we,
  input  logic [SW-1:0]            cfg_addr,
  input  logic [CW-1:0]            cfg_lane,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CW-1:0]            out_lane,
  output logic [SW-1:0]            slot_idx,
  output logic                     frame_start
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CW:0] LNC = (CW+1)'(NUM_CH);
  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_table [SLOTS];
  logic [SW-1:0]       r_slot;
  logic [CW-1:0]       r_rr;
  logic                r_out_valid, r_frame_start;
  logic [DATA_W-1:0]   r_out_data;
  logic [CW-1:0]       r_out_lane;
  logic [CW-1:0]       w_owner, w_rr_sel, w_gnt;
  logic                w_rr_hit, w_own_hit, w_active, w_xfer;
  always_comb begin
    w_state_nxt = cfg_en ? RUN : IDLE;
  end
  // downward scan so the lane nearest rr_ptr is the one left selected
  always_comb begin
    w_rr_sel = '0;
    w_rr_hit = 1'b0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (in_valid[CW'((int'(r_rr) + k) % NUM_CH)]) begin
        w_rr_sel = CW'((int'(r_rr) + k) % NUM_CH);
        w_rr_hit = 1'b1;
      end
    end
  end
  always_comb begin
    w_active  = (r_state == RUN) && cfg_en && !rst;
    w_owner   = r_table[r_slot];
    w_own_hit = in_valid[w_owner];
    w_gnt     = w_own_hit ? w_owner : w_rr_sel;
    w_xfer    = w_active && (w_own_hit || (work_conserve && w_rr_hit));
    in_ready  = w_xfer ? (NUM_CH'(1) << w_gnt) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_slot        <= '0;
      r_rr          <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_lane    <= '0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < SLOTS; i++) r_table[i] <= CW'(i % NUM_CH);
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_active ? r_slot + 1'b1 : '0;
      r_out_valid   <= w_xfer;
      r_frame_start <= w_active && (r_slot == '0);
      if (w_xfer) begin
        r_out_data <= in_data[w_gnt*DATA_W +: DATA_W];
        r_out_lane <= w_gnt;
      end
      if (w_xfer && !w_own_hit) r_rr <= (w_rr_sel == CW'(NUM_CH-1)) ? '0 : w_rr_sel + 1'b1;
      if (cfg_we && ({1'b0, cfg_lane} < LNC)) r_table[cfg_addr] <= cfg_lane;
    end
  end
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_lane    = r_out_lane;
  assign slot_idx    = r_slot;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// tb_tdm_slot_scheduler: directed scenarios plus random traffic against a frame-level reference model.
module tb_tdm_slot_scheduler;
  localparam int N = 4;
  localparam int S = 8;
  logic clk = 1'b0;
  logic rst, cfg_en, work_conserve, cfg_we;
  logic [2:0] cfg_addr;
  logic [1:0] cfg_lane;
  logic [3:0] in_valid, in_data, in_ready;
  logic out_valid;
  logic [0:0] out_data;
  logic [1:0] out_lane;
  logic [2:0] slot_idx;
  logic frame_start;
  int total = 0, bad = 0;
  int m_tbl [S];
  int m_slot = 0, m_rr = 0, m_run = 0, m_ov = 0, m_od = 0, m_ol = 0, m_fs = 0;
  int cnt;

  tdm_slot_scheduler #(.NUM_CH(N), .DATA_W(1), .SLOTS(S)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .work_conserve(work_conserve),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lane(cfg_lane),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_lane(out_lane),
    .slot_idx(slot_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int grant();
    int own;
    if (rst || m_run == 0 || !cfg_en) return -1;
    own = m_tbl[m_slot];
    if (in_valid[own]) return own;
    if (work_conserve)
      for (int k = 0; k < N; k++)
        if (in_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    int g;
    int act;
    #2;
    g = grant();
    chk("in_ready", 32'(in_ready), g < 0 ? 0 : (1 << g));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < S; i++) m_tbl[i] = i % N;
      m_slot = 0; m_rr = 0; m_run = 0; m_ov = 0; m_od = 0; m_ol = 0; m_fs = 0;
    end else begin
      act = (m_run != 0 && cfg_en) ? 1 : 0;
      m_ov = g >= 0 ? 1 : 0;
      if (g >= 0) begin
        m_od = int'(in_data[g]);
        m_ol = g;
        if (g != m_tbl[m_slot]) m_rr = (g + 1) % N;
      end
      m_fs = (act == 1 && m_slot == 0) ? 1 : 0;
      m_slot = act == 1 ? (m_slot + 1) % S : 0;
      m_run = cfg_en ? 1 : 0;
      if (cfg_we && int'(cfg_lane) < N) m_tbl[cfg_addr] = int'(cfg_lane);
    end
    #1;
    chk("out_valid", 32'(out_valid), m_ov);
    chk("out_data", 32'(out_data), m_od);
    chk("out_lane", 32'(out_lane), m_ol);
    chk("slot_idx", 32'(slot_idx), m_slot);
    chk("frame_start", 32'(frame_start), m_fs);
  endtask

  task automatic go_slot(input int s);
    for (int i = 0; i < S && m_slot != s; i++) cycle();
    chk("reach_slot", 32'(m_slot), s);
  endtask

  initial begin
    rst = 1; cfg_en = 0; work_conserve = 0; cfg_we = 0; cfg_addr = 0; cfg_lane = 0;
    in_valid = 0; in_data = 0;
    cycle(); cycle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_slot", 32'(slot_idx), 0);
    chk("rst_lane", 32'(out_lane), 0);
    rst = 0; cfg_en = 1; in_valid = 4'hF;
    cycle();
    for (int i = 0; i < 9; i++) begin
      in_data = 4'($urandom_range(0, 15));
      cycle();
      chk("full_lane", 32'(out_lane), i % 4);
      chk("full_valid", 32'(out_valid), 1);
      chk("full_fs", 32'(frame_start), (i % 8 == 0) ? 1 : 0);
    end
    in_valid = 4'b0100; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      cnt += int'(out_valid);
    end
    chk("strict_count", cnt, 4);
    work_conserve = 1; in_valid = 4'b1010; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_data = 4'($urandom_range(0, 15));
      cycle();
      cnt += int'(out_valid);
    end
    chk("wc_count", cnt, 16);
    work_conserve = 0; in_valid = 4'hF; cfg_we = 1; cfg_lane = 3;
    for (int a = 0; a < S; a++) begin
      cfg_addr = 3'(a);
      cycle();
    end
    cfg_we = 0;
    for (int i = 0; i < S; i++) begin
      cycle();
      chk("all3_lane", 32'(out_lane), 3);
    end
    go_slot(5);
    cfg_we = 1; cfg_addr = 5; cfg_lane = 0;
    cycle();
    cfg_we = 0;
    chk("wr_cur_lane", 32'(out_lane), 3);
    for (int i = 0; i < 7; i++) cycle();
    cycle();
    chk("wr_next_lane", 32'(out_lane), 0);
    go_slot(3);
    cfg_en = 0;
    cycle();
    chk("drop_valid", 32'(out_valid), 0);
    chk("drop_slot", 32'(slot_idx), 0);
    cycle(); cycle();
    cfg_en = 1;
    cycle(); cycle();
    chk("reen_fs", 32'(frame_start), 1);
    chk("reen_valid", 32'(out_valid), 1);
    chk("reen_lane", 32'(out_lane), 3);
    cfg_we = 1; cfg_addr = 0; cfg_lane = 2;
    cycle();
    cfg_we = 0;
    go_slot(4);
    rst = 1;
    cycle();
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_lane", 32'(out_lane), 0);
    chk("mrst_slot", 32'(slot_idx), 0);
    rst = 0;
    cycle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mrst_seq", 32'(out_lane), i);
    end
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cfg_en = ($urandom_range(0, 9) != 0);
      work_conserve = 1'($urandom_range(0, 1));
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_lane = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      in_data = 4'($urandom_range(0, 15));
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdm_slot_scheduler.md
# tdm_slot_scheduler

Time-division scheduler that shares one serial output channel among NUM_CH requesters using a programmable slot table. Each frame has SLOTS slots, and each slot is owned by one lane. An unused slot either idles or, in work-conserving mode, is handed round-robin to another lane. The block generalises the fixed two-input alternating output mux into a configurable, handshaked scheduler that sits in front of the shared output register.

## Interface
- NUM_CH, 4: number of requester lanes; must be ≥2.
- DATA_W, 1: data width per lane.
- SLOTS, 8: slots per frame; must be a power of two and ≥2.
- CW = $clog2(NUM_CH), SW = $clog2(SLOTS): derived widths.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_en  in  1  scheduler enable.
- work_conserve  in  1  1 = reassign unused slots; 0 = strict TDM.
- cfg_we  in  1  slot-table write strobe.
- cfg_addr  in  SW  slot-table entry being written.
- cfg_lane  in  CW  owner lane written to that entry.
- in_valid  in  NUM_CH  per-lane data valid.
- in_data  in  NUM_CH*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-lane grant; combinational, one-hot or zero.
- out_valid  out  1  registered output valid.
- out_data  out  DATA_W  registered output data.
- out_lane  out  CW  lane that produced out_data.
- slot_idx  out  SW  current slot counter.
- frame_start  out  1  registered pulse aligned with the output of slot 0.

## Operation
- **Reset** (rst=1 at an edge):
  - table[i] = i mod NUM_CH.
  - slot_idx=0, rr_ptr=0, state=IDLE.
  - out_valid=0, out_data=0, out_lane=0, frame_start=0.
  - in_ready=0 while rst is high.
- **States:** IDLE and RUN.
  - IDLE → RUN when cfg_en=1. The first RUN cycle serves slot 0.
  - RUN → IDLE when cfg_en=0. slot_idx is forced to 0 at that edge. No grant is issued in a cycle where cfg_en=0.
- **IDLE:** in_ready=0, slot_idx holds 0, and out_valid/frame_start go low on the next edge.
- **Grant selection** (each RUN cycle, combinational; owner = table[slot_idx]):
  - in_valid[owner]=1 → grant owner; rr_ptr unchanged.
  - Otherwise, if work_conserve=1 → grant the first valid lane scanning rr_ptr, rr_ptr+1, … modulo NUM_CH. rr_ptr then becomes (granted lane + 1) mod NUM_CH.
  - Otherwise → no grant.
- **Transfer:** in_ready[g]=1 only for the granted lane. A transfer occurs when in_valid[g] & in_ready[g]. Lanes must hold data stable until they are granted.
- **Output register** (next edge):
  - After a transfer: out_valid=1, out_data=in_data[g], out_lane=g.
  - After a RUN cycle with no transfer: out_valid=0 and out_data/out_lane hold their last values.
- **Slot counter:** slot_idx advances by one every RUN cycle, whether or not a grant occurred. It wraps SLOTS-1 → 0.
- **frame_start:** registered from (RUN && slot_idx==0), so it is aligned with that slot's out_valid.
- **Config writes:**
  - Accepted in any state and take effect at the next edge.
  - A write to the slot currently being served does not affect the current cycle; the new owner applies on the next visit.
  - A write with cfg_lane ≥ NUM_CH is ignored.
  - rst has priority over cfg_we.

## Timing
- Input to output latency is 1 cycle: the grant is in cycle N, and out_* are valid after edge N.
- Peak throughput is one transfer per cycle. A full frame is SLOTS cycles.
- rst mid-frame: all state returns to reset values at that edge, and the table is reinitialised.
- cfg_en falling at slot k: slot k is not served, out_valid=0 from the next edge, and re-enable restarts at slot 0.

## Test plan
- **Default table, full load:** reset, all in_valid=1, cfg_en=1. Expect out_lane 0,1,2,3,0,1,2,3 repeating; frame_start on the 1st and 9th outputs; out_valid continuously 1.
- **Strict mode, one lane:** work_conserve=0, only lane 2 valid. Expect out_valid=1 only for slots 2 and 6 (2 of every 8 cycles); in_ready[2] high only in those slots.
- **Work-conserving reassignment:** work_conserve=1, lanes 1 and 3 valid. Expect out_lane 1,1,3,3,1,1,3,3 with out_valid continuously 1.
- **Table rewrite:**
  - Write all 8 entries to lane 3 with all lanes valid. From the next frame, expect out_lane=3 every cycle.
  - Write entry 5 to lane 0 while slot_idx=5. Expect lane 3 served now and lane 0 at slot 5 of the next frame.
- **Enable drop:** drop cfg_en at slot 3. Expect out_valid=0 the next cycle and slot_idx=0. Re-enable; expect the first output from slot 0 with frame_start=1.
- **Reset mid-operation:** assert rst at slot 4 after table rewrites. Expect out_* = 0, slot_idx=0, and the table restored, so re-enable again yields 0,1,2,3.
